// File: rtl/cla_pipe_adder_pkg.sv
// Shared types, default geometry and the legality check for the pipelined CLA adder.
package cla_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } cla_op_e;

  localparam int CLA_DEF_WIDTH  = 32;
  localparam int CLA_DEF_GROUP  = 4;
  localparam int CLA_DEF_STAGES = 2;

  // WIDTH must split evenly into STAGES slices of whole GROUP-bit leaf blocks.
  function automatic bit cla_check(input int width, input int stages, input int group);
    if (width < 1 || stages < 1 || group < 1) return 1'b0;
    if (width % (stages * group) != 0) return 1'b0;
    return (stages <= width / group);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand-issue and writeback handshake bundle for cla_pipe_adder.
interface cla_pipe_adder_if
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_pipe_adder_group.sv
// GROUP-bit combinational carry-lookahead leaf: sum bits plus group propagate/generate.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             pg,
  output logic             gg
);
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP-1:0] c;
  logic             t_c;
  logic             t_g;

  assign p  = a ^ b;
  assign g  = a & b;
  assign pg = &p;
  assign s  = p ^ c;

  always_comb begin
    c   = '0;
    t_c = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      t_c = ci;
      for (int m = 0; m < i; m++) t_c = t_c & p[m];
      c[i] = t_c;
      for (int j = 0; j < i; j++) begin
        t_c = g[j];
        for (int m = j + 1; m < i; m++) t_c = t_c & p[m];
        c[i] = c[i] | t_c;
      end
    end
  end

  // Kept apart from the carry block so gg never appears to depend on ci.
  always_comb begin
    gg  = 1'b0;
    t_g = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      t_g = g[j];
      for (int m = j + 1; m < GROUP; m++) t_g = t_g & p[m];
      gg = gg | t_g;
    end
  end
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead add/subtract unit, one slice per stage with skewed operands/results.
// Optional signed-overflow output is built only when CLA_PIPE_OVF_EN is defined.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = CLA_DEF_WIDTH,
  parameter int GROUP  = CLA_DEF_GROUP,
  parameter int STAGES = CLA_DEF_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_pipe_adder_if.slave      bus
);
  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / GROUP;

  if (!cla_check(WIDTH, STAGES, GROUP)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*GROUP with STAGES <= WIDTH/GROUP");
  end

  function automatic logic [NG:0] group_carries(input logic [NG-1:0] p,
                                                input logic [NG-1:0] g,
                                                input logic          ci);
    logic [NG:0] c;
    logic        t;
    c = '0;
    for (int i = 0; i <= NG; i++) begin
      t = ci;
      for (int m = 0; m < i; m++) t = t & p[m];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    return c;
  endfunction

  cla_op_e          op;
  logic             en;
  logic             cin_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_out;
  logic [STAGES:0]  vld;
  logic [STAGES:0]  carry_q;
  logic [STAGES-1:0] slice_cout;

  // Subtraction is folded in at the input so later stages only ever add.
  assign op      = cla_op_e'(bus.in_sub);
  assign b_eff   = (op == SUB) ? ~bus.in_b : bus.in_b;
  assign cin_eff = (op == SUB) ? ~bus.in_cin : bus.in_cin;

  assign en            = !vld[STAGES] || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld[STAGES];
  assign bus.out_sum   = sum_out;
  assign bus.out_cout  = carry_q[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      carry_q <= '0;
    end else if (en) begin
      vld     <= {vld[STAGES-1:0], bus.in_valid};
      carry_q <= {slice_cout, cin_eff};
    end
  end

`ifdef CLA_PIPE_OVF_EN
  logic ovf_next;
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_next;
    end
  end

  assign bus.out_ovf = ovf_q;
`else
  assign bus.out_ovf = 1'b0;
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_slice
    logic [SEG-1:0] a_d [s+1];
    logic [SEG-1:0] b_d [s+1];
    logic [SEG-1:0] r_d [STAGES-s];
    logic [SEG-1:0] sum_c;
    logic [NG-1:0]  pg;
    logic [NG-1:0]  gg;
    logic [NG:0]    gc;

    // Operands wait s cycles for their carry; results wait until the top slice is done.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= s; j++) begin
          a_d[j] <= '0;
          b_d[j] <= '0;
        end
        for (int j = 0; j < STAGES - s; j++) r_d[j] <= '0;
      end else if (en) begin
        a_d[0] <= bus.in_a[s*SEG +: SEG];
        b_d[0] <= b_eff[s*SEG +: SEG];
        for (int j = 1; j <= s; j++) begin
          a_d[j] <= a_d[j-1];
          b_d[j] <= b_d[j-1];
        end
        r_d[0] <= sum_c;
        for (int j = 1; j < STAGES - s; j++) r_d[j] <= r_d[j-1];
      end
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a  (a_d[s][g*GROUP +: GROUP]),
        .b  (b_d[s][g*GROUP +: GROUP]),
        .ci (gc[g]),
        .s  (sum_c[g*GROUP +: GROUP]),
        .pg (pg[g]),
        .gg (gg[g])
      );
    end

    assign gc                    = group_carries(pg, gg, carry_q[s]);
    assign slice_cout[s]         = gc[NG];
    assign sum_out[s*SEG +: SEG] = r_d[STAGES-1-s];

`ifdef CLA_PIPE_OVF_EN
    if (s == STAGES - 1) begin : g_ovf
      assign ovf_next = gc[NG] ^ (a_d[s][SEG-1] ^ b_d[s][SEG-1] ^ sum_c[SEG-1]);
    end
`endif
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench: a 32-bit/2-stage and a 64-bit/4-stage adder checked against an arithmetic model.
module tb_cla_pipe_adder;
  import cla_pkg::*;

  localparam int ST32 = 2;
  localparam int ST64 = 4;
  localparam int T    = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(32)) bus32 ();
  cla_pipe_adder_if #(.WIDTH(64)) bus64 ();

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(ST32)) dut32 (
    .clk (clk), .rst_n (rst_n), .bus (bus32)
  );
  cla_pipe_adder #(.WIDTH(64), .GROUP(4), .STAGES(ST64)) dut64 (
    .clk (clk), .rst_n (rst_n), .bus (bus64)
  );

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    time         t_acc;
    bit          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   checks   = 0;
  int   errors   = 0;
  int   pushed32 = 0;
  int   pushed64 = 0;
  int   popped32 = 0;
  int   popped64 = 0;
  int   done_cnt = 0;
  bit   lat_chk  = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Result as plain integer arithmetic: A+B+cin or A-B-cin, borrow and signed range checked directly.
  function automatic exp_t refModel(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input logic sub);
    exp_t        e;
    logic [63:0] mask;
    logic [67:0] ua, ub, uc, ures;
`ifdef CLA_PIPE_OVF_EN
    logic signed [67:0] sa, sb, sc, sres, lim;
`endif
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    ua   = {4'b0, a & mask};
    ub   = {4'b0, b & mask};
    uc   = {67'b0, cin};
    if (sub) begin
      ures   = ua - ub - uc;
      e.cout = (ua >= ub + uc);
    end else begin
      ures   = ua + ub + uc;
      e.cout = ((ures >> w) != 68'd0);
    end
    e.sum = ures[63:0] & mask;
`ifdef CLA_PIPE_OVF_EN
    sa = $signed(ua);
    if (ua[w-1]) sa = sa - (68'sd1 <<< w);
    sb = $signed(ub);
    if (ub[w-1]) sb = sb - (68'sd1 <<< w);
    sc   = $signed(uc);
    sres = sub ? (sa - sb - sc) : (sa + sb + sc);
    lim  = 68'sd1 <<< (w - 1);
    e.ovf = (sres >= lim) || (sres < -lim);
`else
    e.ovf = 1'b0;
`endif
    e.t_acc = 0;
    e.lat   = 1'b0;
    return e;
  endfunction

  task automatic applyStimulus(input int sel, input logic [63:0] a, input logic [63:0] b,
                               input logic cin, input logic sub, output int stalls);
    exp_t e;
    logic rdy;
    int   waited;
    bit   got;
    e     = refModel((sel == 0) ? 32 : 64, a, b, cin, sub);
    e.lat = lat_chk;
    if (sel == 0) begin
      bus32.in_a = a[31:0]; bus32.in_b = b[31:0];
      bus32.in_cin = cin; bus32.in_sub = sub; bus32.in_valid = 1'b1;
    end else begin
      bus64.in_a = a; bus64.in_b = b;
      bus64.in_cin = cin; bus64.in_sub = sub; bus64.in_valid = 1'b1;
    end
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 200) begin
      @(negedge clk);
      rdy = (sel == 0) ? bus32.in_ready : bus64.in_ready;
      @(posedge clk);
      if (rdy) got = 1'b1;
      else waited++;
    end
    stalls = waited;
    if (got) begin
      e.t_acc = $time;
      if (sel == 0) begin q32.push_back(e); pushed32++; end
      else begin q64.push_back(e); pushed64++; end
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout%0d actual=not_accepted required=accepted", sel);
    end
    #1;
    if (sel == 0) bus32.in_valid = 1'b0;
    else bus64.in_valid = 1'b0;
  endtask

  task automatic checkBeat(input int sel, input logic [63:0] sum, input logic cout, input logic ovf);
    exp_t  e;
    bit    have;
    string nm;
    have = 1'b0;
    nm   = (sel == 0) ? "32" : "64";
    if (sel == 0 && q32.size() > 0) begin e = q32.pop_front(); have = 1'b1; popped32++; end
    if (sel == 1 && q64.size() > 0) begin e = q64.pop_front(); have = 1'b1; popped64++; end
    if (!have) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_out%s actual=valid required=idle", nm);
    end else begin
      checkOutput({"sum", nm}, sum, e.sum);
      checkOutput({"cout", nm}, {63'b0, cout}, {63'b0, e.cout});
      checkOutput({"ovf", nm}, {63'b0, ovf}, {63'b0, e.ovf});
      if (e.lat)
        checkOutput({"latency", nm}, $time - e.t_acc, ((sel == 0) ? ST32 : ST64) * T + T / 2);
    end
  endtask

  // Monitor: independent of stimulus, pops one expectation per output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus32.out_valid && bus32.out_ready)
          checkBeat(0, {32'b0, bus32.out_sum}, bus32.out_cout, bus32.out_ovf);
        if (bus64.out_valid && bus64.out_ready)
          checkBeat(1, bus64.out_sum, bus64.out_cout, bus64.out_ovf);
      end
    end
  end

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((q32.size() != 0 || q64.size() != 0) && n < 400);
    if (q32.size() != 0 || q64.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_%s actual=%0d/%0d pending required=0", name, q32.size(), q64.size());
    end
    #1;
  endtask

  task automatic resetMidFlight(input int sel);
    int   st;
    logic v;
    applyStimulus(sel, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, st);
    applyStimulus(sel, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, st);
    rst_n = 1'b0;
    if (sel == 0) begin pushed32 -= q32.size(); q32.delete(); end
    else begin pushed64 -= q64.size(); q64.delete(); end
    #1;
    v = (sel == 0) ? bus32.out_valid : bus64.out_valid;
    checkOutput("rst_valid_now", {63'b0, v}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (((sel == 0) ? ST32 : ST64) + 2) begin
      @(negedge clk);
      v = (sel == 0) ? bus32.out_valid : bus64.out_valid;
      checkOutput("rst_no_stale", {63'b0, v}, 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    bus32.in_valid = 1'b0; bus32.in_a = '0; bus32.in_b = '0;
    bus32.in_cin = 1'b0; bus32.in_sub = 1'b0; bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_a = '0; bus64.in_b = '0;
    bus64.in_cin = 1'b0; bus64.in_sub = 1'b0; bus64.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid32", {63'b0, bus32.out_valid}, 64'd0);
    checkOutput("rst_sum32", {32'b0, bus32.out_sum}, 64'd0);
    checkOutput("rst_cout32", {63'b0, bus32.out_cout}, 64'd0);
    checkOutput("rst_ovf32", {63'b0, bus32.out_ovf}, 64'd0);
    checkOutput("rst_valid64", {63'b0, bus64.out_valid}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready32_after_rst", {63'b0, bus32.in_ready}, 64'd1);
    checkOutput("ready64_after_rst", {63'b0, bus64.in_ready}, 64'd1);
    @(posedge clk);
    #1;

    $display("[TB] directed arithmetic and latency");
    lat_chk = 1'b1;
    applyStimulus(0, 64'hFFFF_FFFF, 64'h1, 1'b0, ADD, st);
    applyStimulus(0, 64'h5, 64'h7, 1'b0, SUB, st);
    applyStimulus(0, 64'h7FFF_FFFF, 64'h1, 1'b0, ADD, st);
    applyStimulus(1, {64{1'b1}}, 64'h1, 1'b0, ADD, st);
    applyStimulus(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, ADD, st);
    waitDrain("directed");

    $display("[TB] back-to-back");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, {32'b0, $urandom}, {32'b0, $urandom}, 1'($urandom_range(1)),
                    1'($urandom_range(1)), st);
      checkOutput("b2b_stall", st, 64'd0);
    end
    waitDrain("b2b");
    lat_chk = 1'b0;

    $display("[TB] backpressure");
    bus32.out_ready = 1'b0;
    for (int i = 0; i < ST32 + 1; i++)
      applyStimulus(0, {32'b0, $urandom}, {32'b0, $urandom}, 1'b0, 1'($urandom_range(1)), st);
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_valid", {63'b0, bus32.out_valid}, 64'd1);
      checkOutput("bp_in_ready", {63'b0, bus32.in_ready}, 64'd0);
      checkOutput("bp_sum_held", {32'b0, bus32.out_sum}, q32[0].sum);
      checkOutput("bp_cout_held", {63'b0, bus32.out_cout}, {63'b0, q32[0].cout});
    end
    @(posedge clk);
    #1;
    bus32.out_ready = 1'b1;
    waitDrain("backpressure");

    $display("[TB] reset mid-flight");
    resetMidFlight(0);
    resetMidFlight(1);

    $display("[TB] random traffic");
    fork
      begin : stim32
        int s32;
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
          applyStimulus(0, ($urandom_range(7) == 0) ? 64'hFFFF_FFFF : {32'b0, $urandom},
                        {32'b0, $urandom}, 1'($urandom_range(1)), 1'($urandom_range(1)), s32);
        end
        done_cnt++;
      end
      begin : stim64
        int s64;
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
          applyStimulus(1, ($urandom_range(7) == 0) ? {64{1'b1}} : {$urandom, $urandom},
                        {$urandom, $urandom}, 1'($urandom_range(1)), 1'($urandom_range(1)), s64);
        end
        done_cnt++;
      end
      begin : sink
        while (done_cnt < 2) begin
          @(posedge clk);
          #1;
          bus32.out_ready = ($urandom_range(3) != 0);
          bus64.out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    bus32.out_ready = 1'b1;
    bus64.out_ready = 1'b1;
    waitDrain("random");

    checkOutput("count32", popped32, pushed32);
    checkOutput("count64", popped64, pushed64);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
